// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial a - b (LSB first) built from one full-subtractor cell
//            and a borrow flop, behind a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_diff;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_bw;
    logic               r_busy;
    logic               r_done;
    logic               r_borrow_out;
    logic               r_overflow;

    logic               w_x;
    logic               w_y;
    logic               w_d;
    logic               w_bw_next;
    logic               w_last;

    // Full-subtractor cell: the only arithmetic in the datapath.
    assign w_x       = r_sa[0];
    assign w_y       = r_sb[0];
    assign w_d       = w_x ^ w_y ^ r_bw;
    assign w_bw_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_bw);
    assign w_last    = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa         <= '0;
            r_sb         <= '0;
            r_sr         <= '0;
            r_diff       <= '0;
            r_cnt        <= '0;
            r_sign_a     <= 1'b0;
            r_sign_b     <= 1'b0;
            r_bw         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_sign_a <= a[WIDTH-1];
                        r_sign_b <= b[WIDTH-1];
                        r_bw     <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_sr  <= {w_d, r_sr[WIDTH-1:1]};
                    r_bw  <= w_bw_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // The final cell output is the result sign bit.
                        r_diff       <= {w_d, r_sr[WIDTH-1:1]};
                        r_borrow_out <= w_bw_next;
                        r_overflow   <= (r_sign_a != r_sign_b) && (w_d != r_sign_a);
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor against an arithmetic
//            reference model, with directed and random operand pairs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int vectors     = 0;
    int miscompares = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        int ua, ub, sa, sb, sd;
        logic [W-1:0] d;
        logic bo, ov;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        sd = sa - sb;
        d  = W'(ua - ub);
        bo = (ua < ub);
        ov = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        return {ov, bo, d};
    endfunction

    // One operation: accept, WIDTH busy cycles, one done cycle, then done low.
    // With disturb set, a/b/start are scrambled throughout the busy window.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input bit disturb, input string name);
        logic [W+1:0] exp;
        logic [W-1:0] prev;
        exp  = model(ta, tb_v);
        prev = diff;
        a = ta; b = tb_v; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== prev) begin
                miscompares++;
                $display("FAIL %s busy-window cyc%0d: busy=%b done=%b diff=%h, want busy=1 done=0 diff=%h",
                         name, i, busy, done, diff, prev);
            end
            if (disturb) begin
                a = W'($urandom); b = W'($urandom); start = 1'($urandom);
            end
            tick();
        end
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || diff !== exp[W-1:0] ||
            borrow_out !== exp[W] || overflow !== exp[W+1]) begin
            miscompares++;
            $display("FAIL %s result: done=%b busy=%b diff=%h bo=%b ov=%b, want done=1 busy=0 diff=%h bo=%b ov=%b",
                     name, done, busy, diff, borrow_out, overflow, exp[W-1:0], exp[W], exp[W+1]);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== exp[W-1:0]) begin
            miscompares++;
            $display("FAIL %s after-done: done=%b busy=%b diff=%h, want done=0 busy=0 diff=%h",
                     name, done, busy, diff, exp[W-1:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b diff=%h bo=%b ov=%b, want all zero",
                     busy, done, diff, borrow_out, overflow);
        end
        tick();
    endtask

    task automatic test_directed();
        run_op(8'd200, 8'd55,  1'b0, "200-55");
        run_op(8'd5,   8'd9,   1'b0, "5-9");
        run_op(8'hA5,  8'hA5,  1'b0, "a5-a5");
        run_op(8'h80,  8'h01,  1'b0, "80-01");
        run_op(8'h7F,  8'hFF,  1'b0, "7f-ff");
    endtask

    task automatic test_ignore_start();
        logic [W+1:0] exp;
        exp = model(8'd10, 8'd3);
        a = 8'd10; b = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == 2) begin
                a = 8'd1; b = 8'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || diff !== exp[W-1:0] || borrow_out !== exp[W]) begin
            miscompares++;
            $display("FAIL ignore_start: done=%b diff=%h bo=%b, want done=1 diff=%h bo=%b",
                     done, diff, borrow_out, exp[W-1:0], exp[W]);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start idle: busy=%b done=%b, want 0 0", busy, done);
        end
        run_op(8'd10, 8'd3, 1'b1, "disturbed 10-3");
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] e1, e2;
        e1 = model(8'd20, 8'd4);
        e2 = model(8'd4, 8'd20);
        a = 8'd20; b = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) tick();
        vectors++;
        if (done !== 1'b1 || diff !== e1[W-1:0]) begin
            miscompares++;
            $display("FAIL b2b first: done=%b diff=%h, want done=1 diff=%h", done, diff, e1[W-1:0]);
        end
        a = 8'd4; b = 8'd20; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== e1[W-1:0]) begin
                miscompares++;
                $display("FAIL b2b hold cyc%0d: busy=%b done=%b diff=%h, want busy=1 done=0 diff=%h",
                         i, busy, done, diff, e1[W-1:0]);
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1 || diff !== e2[W-1:0] || borrow_out !== e2[W]) begin
            miscompares++;
            $display("FAIL b2b second: done=%b diff=%h bo=%b, want done=1 diff=%h bo=%b",
                     done, diff, borrow_out, e2[W-1:0], e2[W]);
        end
        tick();
    endtask

    task automatic test_abort();
        a = 8'd100; b = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: busy=%b done=%b diff=%h bo=%b ov=%b, want all zero",
                     busy, done, diff, borrow_out, overflow);
        end
        for (int i = 0; i < W + 4; i++) begin
            tick();
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort quiet cyc%0d: busy=%b done=%b, want 0 0", i, busy, done);
            end
        end
        run_op(8'd100, 8'd1, 1'b0, "after-abort 100-1");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor: computes a − b, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a borrow flip-flop. It is the inverse counterpart of the ripple full-adder datapath.
- Sits beside the adder in the lab arithmetic path. Serves as an area-minimal SUB unit behind a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when not busy
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  a − b mod 2^WIDTH
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned)
- overflow  output  1  signed overflow of a − b

Behaviour:
- Reset: one clock and one synchronous, active-high reset (rst). Sampled on the clk rising edge. Forces state=IDLE. Sets busy=0, done=0, diff=0, borrow_out=0, overflow=0. Clears the internal shift registers, borrow flip-flop and bit counter.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge where start=1: latch a into sa, b into sb, and a[WIDTH-1], b[WIDTH-1] into sign flops.
  - Clear borrow, set cnt=0, busy←1, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, each edge, using the bit cell on x=sa[0], y=sb[0], bw=borrow:
  - d = x^y^bw
  - bw_next = (~x&y) | (~(x^y)&bw)
  - sa, sb shift right by 1.
  - The result shift register sr shifts right, with d entering at the MSB.
  - borrow←bw_next; cnt←cnt+1.
- Last bit (cnt==WIDTH-1) on that same edge:
  - diff←{d, sr[WIDTH-1:1]} (full result).
  - borrow_out←bw_next.
  - overflow←(sign_a≠sign_b) && (d≠sign_a).
  - done←1, busy←0, state→IDLE.
- Latency: start sampled at edge k. done is high in the cycle after edge k+WIDTH, i.e. exactly WIDTH cycles of busy. Throughput is one result per WIDTH cycles.
- done is a single-cycle pulse, cleared on the next edge.
- diff, borrow_out and overflow hold the last result until the next completion or reset. They do not change during SHIFT; intermediate bits are visible only in internal sr.
- start while busy=1: ignored, with no effect on operands or progress.
- start in the done cycle (state=IDLE): accepted. This allows back-to-back operation with no gap cycle; done falls and busy rises on the same edge.
- a/b changes after acceptance do not affect the operation in flight.
- rst mid-operation (any cycle of SHIFT): abort immediately to reset values. No done pulse is produced for the aborted operation.
- cnt width is clog2(WIDTH)+1. No wrap-around is possible because SHIFT exits at WIDTH-1.
- Combinational bit cell and flip-flops only; no multi-bit subtract operator in the datapath.

Test Plan:
- WIDTH=8, a=200, b=55, single start pulse → busy high for 8 cycles, then done for 1 cycle; diff=145 (0x91), borrow_out=0, overflow=0.
- a=5, b=9 → diff=0xFC (252), borrow_out=1, overflow=0. Also a=b=0xA5 → diff=0, borrow_out=0, overflow=0.
- a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1. Also a=0x7F, b=0xFF → diff=0x80, borrow_out=1, overflow=1.
- Start a=10, b=3, then pulse start with a=1, b=2 at cycle 3 of busy → second request ignored; result diff=7, borrow_out=0. Change a/b mid-operation → result unaffected.
- Back-to-back: start a=20, b=4; assert start with a=4, b=20 in the done cycle → first done gives diff=16. Second done arrives exactly 8 cycles later with diff=0xF0, borrow_out=1. diff holds 16 between the two done pulses.
- Start a=100, b=1; assert rst at cycle 4 of busy → next cycle busy=0, done=0, diff=0, borrow_out=0, overflow=0, and no done pulse follows. A new start after reset completes normally.
